// File: rtl/cla32_rr_arbiter.sv
// Round-robin arbiter that shares one 32-bit carry-lookahead adder among
// N_REQ add/subtract requesters. One operation is in flight at a time:
// grant (IDLE) -> add (EXEC) -> present result until accepted (DONE).
`timescale 1ns/1ps

module cla32_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [N_REQ-1:0]      req_sub,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_sum,
    output logic                  res_cout,
    output logic                  res_ovf,
    output logic [ID_W-1:0]       res_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [ID_W-1:0]     ptr_r;
    logic [ID_W-1:0]     win_s;
    logic [N_REQ-1:0]    win_oh_s;
    logic                found_s;
    logic                grant_s;

    logic [31:0]         sel_a_s;
    logic [31:0]         sel_b_s;
    logic                sel_sub_s;

    logic [31:0]         a_r;
    logic [31:0]         b_r;
    logic                sub_r;
    logic [ID_W-1:0]     id_r;

    logic [31:0]         b_eff_s;
    logic [31:0]         add_sum_s;
    logic                add_cout_s;
    logic                add_ovf_s;

    // Round-robin search: first valid requester at or above ptr, wrapping to 0
    always_comb begin
        logic [ID_W:0]   sum_v;
        logic [ID_W:0]   wide_v;
        logic [ID_W-1:0] cand_v;
        logic            hit_v;
        found_s  = 1'b0;
        win_s    = {ID_W{1'b0}};
        win_oh_s = {N_REQ{1'b0}};
        sum_v    = {(ID_W+1){1'b0}};
        wide_v   = {(ID_W+1){1'b0}};
        cand_v   = {ID_W{1'b0}};
        hit_v    = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            sum_v  = {1'b0, ptr_r} + (ID_W+1)'(off);
            wide_v = (sum_v >= (ID_W+1)'(N_REQ)) ? (sum_v - (ID_W+1)'(N_REQ)) : sum_v;
            cand_v = wide_v[ID_W-1:0];
            hit_v  = req_valid[cand_v] & ~found_s;
            win_oh_s[cand_v] = win_oh_s[cand_v] | hit_v;
            win_s   = hit_v ? cand_v : win_s;
            found_s = found_s | hit_v;
        end
    end

    assign grant_s = (state_r == ST_IDLE) && found_s;

    // Operand select for the winning requester (AND-OR mux on the one-hot winner)
    always_comb begin
        sel_a_s   = 32'd0;
        sel_b_s   = 32'd0;
        sel_sub_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s   = sel_a_s | (req_a[32*i +: 32] & {32{win_oh_s[i]}});
            sel_b_s   = sel_b_s | (req_b[32*i +: 32] & {32{win_oh_s[i]}});
            sel_sub_s = sel_sub_s | (req_sub[i] & win_oh_s[i]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) state_nxt_s = ST_EXEC;
                else         state_nxt_s = ST_IDLE;
            end
            ST_EXEC: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (res_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: grant is offered only while IDLE
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (found_s) req_ready = win_oh_s;
                else         req_ready = {N_REQ{1'b0}};
            end
            default: req_ready = {N_REQ{1'b0}};
        endcase
    end

    // Capture granted operands and advance the round-robin pointer past the winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            sub_r <= 1'b0;
            id_r  <= {ID_W{1'b0}};
            ptr_r <= {ID_W{1'b0}};
        end else if (grant_s) begin
            a_r   <= sel_a_s;
            b_r   <= sel_b_s;
            sub_r <= sel_sub_s;
            id_r  <= win_s;
            ptr_r <= (win_s == ID_W'(N_REQ-1)) ? {ID_W{1'b0}} : (win_s + ID_W'(1));
        end
    end

    // Subtract is A + ~B + 1; overflow judged on the post-inversion operand
    assign b_eff_s   = sub_r ? ~b_r : b_r;
    assign add_ovf_s = (a_r[31] == b_eff_s[31]) & (add_sum_s[31] != a_r[31]);

    CLA_32bit u_adder (
        .a    (a_r),
        .b    (b_eff_s),
        .cin  (sub_r),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Result register: load at the end of EXEC, hold through DONE until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= 32'd0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
            res_id    <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                ST_EXEC: begin
                    res_valid <= 1'b1;
                    res_sum   <= add_sum_s;
                    res_cout  <= add_cout_s;
                    res_ovf   <= add_ovf_s;
                    res_id    <= id_r;
                end
                ST_DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: res_valid <= res_valid;
            endcase
        end
    end

endmodule

// 32-bit carry-lookahead adder: 4-bit groups with in-group lookahead terms
// and a group-level generate/propagate carry chain. Group P/G stay internal.
module CLA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g_s;
    logic [31:0] p_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Per-group sums from the incoming group carry; group carry via group G/P
    always_comb begin
        logic gc_v;
        logic bg_v;
        logic bp_v;
        logic c_v;
        sum  = 32'd0;
        gc_v = cin;
        bg_v = 1'b0;
        bp_v = 1'b0;
        c_v  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bg_v = g_s[4*k+3]
                 | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            bp_v = &p_s[4*k +: 4];
            c_v  = gc_v;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p_s[4*k+j] ^ c_v;
                c_v        = g_s[4*k+j] | (p_s[4*k+j] & c_v);
            end
            gc_v = bg_v | (bp_v & gc_v);
        end
        cout = gc_v;
    end

endmodule

// File: doc/cla32_rr_arbiter.md
# cla32_rr_arbiter

Round-robin arbiter and sequencer that shares one `CLA_32bit` adder among `N_REQ` requesters. Each requester presents an add or subtract request with a valid/ready handshake. The block grants one requester at a time, registers its operands and drives the shared adder. It then presents the registered sum, carry-out and signed overflow on a single result port, held until accepted. It sits between the client datapaths and the adder as the only owner of the adder instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8); `ID_W = $clog2(N_REQ)`
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_ready`  out  N_REQ  per-requester grant/accept (one-hot or zero)
- `req_a`  in  32*N_REQ  operand A, requester i at bits [32i+31:32i]
- `req_b`  in  32*N_REQ  operand B, same packing
- `req_sub`  in  N_REQ  1 = A−B, 0 = A+B
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result consumer accept
- `res_sum`  out  32  sum/difference
- `res_cout`  out  1  adder carry-out (for subtract: 1 = no borrow)
- `res_ovf`  out  1  two's-complement signed overflow
- `res_id`  out  ID_W  index of the requester that owns the result

## Operation
- States: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `ptr` upward with wrap N_REQ−1 → 0.
  - `req_ready[winner]`=1 combinationally in IDLE only; all other bits are 0.
  - No valid request: `req_ready`=0 and the block stays in IDLE.
- Grant (IDLE and `req_valid[w]`): on the clock edge, capture `a_r`, `b_r`, `sub_r` and `id_r=w`. Set `ptr` ← (w+1) mod N_REQ, then go to EXEC.
- EXEC: the adder is fed `a_r`, `sub_r ? ~b_r : b_r`, and cin=`sub_r`. On the edge, register `res_sum`, `res_cout`, `res_ovf` and `res_id=id_r`; set `res_valid`=1 and go to DONE.
- Overflow: `ovf = (a_r[31] == b'[31]) & (s[31] != a_r[31])`, where b' is the post-inversion operand. Adder GP/GG outputs are unused.
- DONE:
  - Result outputs are held stable while `res_valid`=1.
  - On `res_ready`=1: `res_valid` clears on the edge and the block returns to IDLE.
  - `req_ready`=0 throughout EXEC and DONE.
- Requester protocol: once `req_valid[i]` is raised, it and the operands stay stable until `req_ready[i]`. Dropping `req_valid` before grant is tolerated; that requester is simply skipped.
- `res_ready` high while not in DONE has no effect.

## Timing
- Reset (async assert, sync-safe deassert):
  - `res_valid`, `res_sum`, `res_cout`, `res_ovf`, `res_id` = 0.
  - `req_ready` = 0; `ptr` = 0; state = IDLE.
  - An in-flight request is discarded with no result.
- Latency: grant edge at cycle T → `res_valid`=1 from cycle T+2.
- Best-case throughput: one operation per 3 cycles, with `res_ready` tied high (grant, EXEC, DONE+accept).
- `res_ready` already high when `res_valid` rises: the result is accepted on the first DONE edge, and the next grant is possible the cycle after.
- Fairness: a continuously requesting client is granted within N_REQ grants.
- The adder path is one full cycle (EXEC), with registered inputs and registered outputs, so no combinational path from `req_*` to `res_*`.

## Test plan
- Reset mid-EXEC:
  - Stimulus: grant req0 (A=1, B=2), assert `rst_n`=0 during EXEC.
  - Required: all outputs 0 immediately; after release, no result appears and `ptr`=0.
- Single add:
  - Stimulus: req1 A=0xFFFF_FFFF, B=0x0000_0001, sub=0.
  - Required: `res_valid` at T+2 with sum=0x0000_0000, cout=1, ovf=0, id=1.
- Subtract and overflow:
  - Stimulus: req2 A=0x8000_0000, B=0x0000_0001, sub=1.
  - Required: sum=0x7FFF_FFFF, cout=1, ovf=1.
  - Stimulus: A=3, B=5, sub=1.
  - Required: sum=0xFFFF_FFFE, cout=0, ovf=0.
- Round-robin and wrap:
  - Stimulus: all four `req_valid` held high with `res_ready`=1.
  - Required: grant order 0,1,2,3,0,…, `res_id` matching, one result every 3 cycles.
  - Stimulus: only req3 and req0 valid.
  - Required: grants alternate 3,0,3.
- Backpressure:
  - Stimulus: hold `res_ready`=0 for 10 cycles after `res_valid` with req0 valid pending.
  - Required: result outputs are stable, `req_ready`=0 throughout; the grant to req0 occurs in the cycle after `res_ready` is accepted.
